// File: rtl/vga_capture.sv
// Sink-side VGA monitor: recovers pixel position from the sync pins, verifies line and
// frame timing, locks, and streams active pixels. VGA_CAPTURE_CHECKSUM_EN adds the per-frame checksum.
module vga_capture #(
    parameter int H_TOTAL         = 800,
    parameter int H_START         = 144,
    parameter int H_ACTIVE        = 640,
    parameter int V_TOTAL         = 525,
    parameter int V_START         = 35,
    parameter int V_ACTIVE        = 480,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        en,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic [1:0]  vga_r,
    input  logic [1:0]  vga_g,
    input  logic [1:0]  vga_b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [5:0]  pix_color,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [7:0]  err_count
);

    localparam logic [10:0] H_TOT_W = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT_W = 11'(V_TOTAL);
    localparam logic [9:0]  H_BEG   = 10'(H_START);
    localparam logic [9:0]  H_END   = 10'(H_START + H_ACTIVE);
    localparam logic [9:0]  V_BEG   = 10'(V_START);
    localparam logic [9:0]  V_END   = 10'(V_START + V_ACTIVE);
    localparam logic [8:0]  V_BEG9  = 9'(V_START);
    localparam logic [3:0]  LOCK_W  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, SYNCING, LOCKED} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state, state_nx;
    logic [3:0]  good_cnt, good_nx;
    logic        armed, armed_nx, seen_bad, seen_nx;
    logic        err_inc, publish;

    logic        hs_p1, vs_p1, hs_d1, vs_d1;
    logic [5:0]  col_p1;
    logic        hs_edge, vs_edge;
    logic [9:0]  hcnt, lcnt, h_pos, l_pos, x_off;
    logic [8:0]  y_off;
    logic        line_bad, frame_bad, active, pix_ok;

    // Stage p1: register pins, normalise sync polarity
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
            hs_d1  <= 1'b0;
            vs_d1  <= 1'b0;
            col_p1 <= '0;
        end else begin
            hs_p1  <= (SYNC_ACTIVE_LOW != 0) ? ~vga_hsync : vga_hsync;
            vs_p1  <= (SYNC_ACTIVE_LOW != 0) ? ~vga_vsync : vga_vsync;
            hs_d1  <= hs_p1;
            vs_d1  <= vs_p1;
            col_p1 <= {vga_b, vga_g, vga_r};
        end
    end

    // hcnt/lcnt hold the position of the previous p1 pixel; h_pos/l_pos are the current one
    always_comb begin
        hs_edge   = hs_p1 & ~hs_d1;
        vs_edge   = vs_p1 & ~vs_d1;
        h_pos     = hs_edge ? 10'd0 : hcnt + 10'd1;
        l_pos     = vs_edge ? 10'd0 : (hs_edge ? lcnt + 10'd1 : lcnt);
        line_bad  = hs_edge & armed & (({1'b0, hcnt} + 11'd1) != H_TOT_W);
        frame_bad = line_bad | seen_bad | (({1'b0, lcnt} + 11'd1) != V_TOT_W);
        active    = (h_pos >= H_BEG) && (h_pos < H_END) && (l_pos >= V_BEG) && (l_pos < V_END);
        x_off     = h_pos - H_BEG;
        y_off     = l_pos[8:0] - V_BEG9;
    end

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        armed_nx = armed;
        seen_nx  = seen_bad;
        err_inc  = 1'b0;
        publish  = 1'b0;
        if (!en) begin
            state_nx = SEARCH;
            good_nx  = '0;
            armed_nx = 1'b0;
            seen_nx  = 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    armed_nx = 1'b0;
                    seen_nx  = 1'b0;
                    if (vs_edge) begin
                        state_nx = SYNCING;
                        good_nx  = '0;
                    end
                end
                SYNCING: begin
                    if (hs_edge) armed_nx = 1'b1;
                    if (line_bad) seen_nx = 1'b1;
                    if (vs_edge) begin
                        seen_nx = 1'b0;
                        if (frame_bad) begin
                            good_nx = '0;
                        end else begin
                            good_nx = good_cnt + 4'd1;
                            if (good_cnt + 4'd1 == LOCK_W) state_nx = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (line_bad || (vs_edge && frame_bad)) begin
                        state_nx = SEARCH;
                        good_nx  = '0;
                        armed_nx = 1'b0;
                        seen_nx  = 1'b0;
                        err_inc  = 1'b1;
                    end else if (vs_edge) begin
                        publish = 1'b1;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
        pix_ok = active && (state == LOCKED) && (state_nx == LOCKED);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= SEARCH;
            good_cnt  <= '0;
            armed     <= 1'b0;
            seen_bad  <= 1'b0;
            hcnt      <= '0;
            lcnt      <= '0;
            err_count <= '0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
            armed    <= armed_nx;
            seen_bad <= seen_nx;
            hcnt     <= h_pos;
            lcnt     <= l_pos;
            if (err_inc) err_count <= sat_inc8(err_count);
        end
    end

    // Stage p2: output register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_color  <= '0;
            frame_done <= 1'b0;
        end else begin
            pix_valid  <= pix_ok;
            pix_x      <= pix_ok ? x_off : 10'd0;
            pix_y      <= pix_ok ? y_off : 9'd0;
            pix_color  <= pix_ok ? col_p1 : 6'd0;
            frame_done <= publish;
        end
    end

    assign locked = (state == LOCKED);

`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sum       <= '0;
            frame_sum <= '0;
        end else if (!en) begin
            sum       <= '0;
            frame_sum <= '0;
        end else if (publish) begin
            frame_sum <= sum;
            sum       <= '0;
        end else if (state_nx != LOCKED) begin
            sum <= '0;
        end else if (pix_ok) begin
            sum <= sum + {10'd0, col_p1};
        end
    end
`else
    assign frame_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 24x14 raster; a second instance runs
// with active-high syncs to cover the polarity option.
module tb_vga_capture;

    localparam int HT = 24, HS0 = 6, HA = 12, VT = 14, VS0 = 3, VA = 8, HSW = 3, VSW = 2;
`ifdef VGA_CAPTURE_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam logic [15:0] FULL_SUM = 16'((HA * VA * 63) % 65536);
    localparam logic [15:0] EXP_FULL = CSUM ? FULL_SUM : 16'h0000;
    localparam logic [15:0] EXP_ONE  = CSUM ? 16'h0015 : 16'h0000;

    logic        clk = 1'b0;
    logic        nRst, en, hs_pin, vs_pin, hs_pin2, vs_pin2;
    logic [1:0]  r, g, b;
    logic        pix_valid, locked, frame_done;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [5:0]  pix_color;
    logic [15:0] frame_sum;
    logic [7:0]  err_count;
    logic        pix_valid_h, locked_h, frame_done_h;
    logic [9:0]  pix_x_h;
    logic [8:0]  pix_y_h;
    logic [5:0]  pix_color_h;
    logic [15:0] frame_sum_h;
    logic [7:0]  err_count_h;

    always #5 clk = ~clk;

    vga_capture #(.H_TOTAL(HT), .H_START(HS0), .H_ACTIVE(HA), .V_TOTAL(VT), .V_START(VS0),
                  .V_ACTIVE(VA), .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)) dut (
        .clk(clk), .nRst(nRst), .en(en), .vga_hsync(hs_pin), .vga_vsync(vs_pin),
        .vga_r(r), .vga_g(g), .vga_b(b), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_color(pix_color), .locked(locked), .frame_done(frame_done),
        .frame_sum(frame_sum), .err_count(err_count));

    vga_capture #(.H_TOTAL(HT), .H_START(HS0), .H_ACTIVE(HA), .V_TOTAL(VT), .V_START(VS0),
                  .V_ACTIVE(VA), .SYNC_ACTIVE_LOW(0), .LOCK_FRAMES(2)) dut_hi (
        .clk(clk), .nRst(nRst), .en(en), .vga_hsync(hs_pin2), .vga_vsync(vs_pin2),
        .vga_r(r), .vga_g(g), .vga_b(b), .pix_valid(pix_valid_h), .pix_x(pix_x_h), .pix_y(pix_y_h),
        .pix_color(pix_color_h), .locked(locked_h), .frame_done(frame_done_h),
        .frame_sum(frame_sum_h), .err_count(err_count_h));

    int checks = 0, errors = 0;
    int cyc = 0;
    int lock_rise, lock_fall, lock_rise_h, fd_cnt, fd_cnt_h, first_fd;
    int vcnt, valid_after_fall, first_valid, nvs, pix00_cyc, hs_err_cyc;
    int vs_cyc[0:7];
    logic [15:0] fd_sum[0:7];
    logic [15:0] last_fs_h;
    logic [9:0]  fx, lx;
    logic [8:0]  fy, ly;
    logic [5:0]  fc;
    logic        prev_locked = 1'b0, prev_locked_h = 1'b0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_trk();
        lock_rise = -1; lock_fall = -1; lock_rise_h = -1;
        fd_cnt = 0; fd_cnt_h = 0; first_fd = -1; last_fs_h = '0;
        vcnt = 0; valid_after_fall = 0; first_valid = -1; nvs = 0;
        pix00_cyc = -1; hs_err_cyc = -1;
        for (int i = 0; i < 8; i++) begin vs_cyc[i] = -1; fd_sum[i] = '0; end
    endtask

    // Observe outputs at the falling edge, then drive the next pin values
    task automatic tick(input logic hs, input logic vs, input logic [5:0] col);
        @(negedge clk);
        cyc++;
        if (locked && !prev_locked && lock_rise < 0) lock_rise = cyc;
        if (!locked && prev_locked && lock_fall < 0) lock_fall = cyc;
        if (locked_h && !prev_locked_h && lock_rise_h < 0) lock_rise_h = cyc;
        prev_locked = locked;
        prev_locked_h = locked_h;
        if (frame_done) begin
            if (fd_cnt < 8) fd_sum[fd_cnt] = frame_sum;
            if (fd_cnt == 0) first_fd = cyc;
            fd_cnt++;
        end
        if (frame_done_h) begin fd_cnt_h++; last_fs_h = frame_sum_h; end
        if (pix_valid) begin
            vcnt++;
            if (first_valid < 0) begin first_valid = cyc; fx = pix_x; fy = pix_y; fc = pix_color; end
            lx = pix_x; ly = pix_y;
            if (lock_fall >= 0) valid_after_fall++;
        end
        hs_pin = ~hs; vs_pin = ~vs; hs_pin2 = hs; vs_pin2 = vs;
        {b, g, r} = col;
    endtask

    // mode 0: constant 6'h3F; mode 1: single 6'h15 pixel at (0,0), rest black
    task automatic gen_frame(input int nlines, input int short_line, input int mode);
        for (int l = 0; l < nlines; l++) begin
            for (int h = 0; h < ((l == short_line) ? HT - 1 : HT); h++) begin
                logic [5:0] col;
                logic act;
                act = (h >= HS0) && (h < HS0 + HA) && (l >= VS0) && (l < VS0 + VA);
                col = 6'h00;
                if (act && mode == 0) col = 6'h3F;
                if (act && mode == 1 && h == HS0 && l == VS0) col = 6'h15;
                tick(h < HSW, l < VSW, col);
                if (h == 0 && l == 0 && nvs < 8) begin vs_cyc[nvs] = cyc; nvs++; end
                if (short_line >= 0 && h == 0 && l == short_line + 1) hs_err_cyc = cyc;
                if (mode == 1 && col == 6'h15) pix00_cyc = cyc;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0; en = 1'b1;
        hs_pin = 1'b1; vs_pin = 1'b1; hs_pin2 = 1'b0; vs_pin2 = 1'b0;
        r = '0; g = '0; b = '0;
        clear_trk();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 6'h00);
        chk("reset_locked", locked, 0);
        chk("reset_valid", pix_valid, 0);
        chk("reset_err", err_count, 0);
        chk("reset_sum", frame_sum, 0);
        chk("reset_fdone", frame_done, 0);
        chk("reset_pix_x", pix_x, 0);
        nRst = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 6'h00);

        // Lock and checksum, both polarities
        clear_trk();
        for (int f = 0; f < 5; f++) gen_frame(VT, -1, 0);
        chk("lock_at_3rd_vsync", lock_rise, vs_cyc[2] + 2);
        chk("first_fdone_4th_vsync", first_fd, vs_cyc[3] + 2);
        chk("fdone_count", fd_cnt, 2);
        chk("frame_sum_const_a", fd_sum[0], EXP_FULL);
        chk("frame_sum_const_b", fd_sum[1], EXP_FULL);
        chk("valid_pixel_count", vcnt, 3 * HA * VA);
        chk("err_after_lock", err_count, 0);
        chk("hi_pol_lock", lock_rise_h, vs_cyc[2] + 2);
        chk("hi_pol_fdone_count", fd_cnt_h, 2);
        chk("hi_pol_frame_sum", last_fs_h, EXP_FULL);

        // Single pixel
        clear_trk();
        gen_frame(VT, -1, 1);
        gen_frame(VT, -1, 0);
        chk("single_latency", first_valid, pix00_cyc + 2);
        chk("single_x", fx, 0);
        chk("single_y", fy, 0);
        chk("single_color", fc, 6'h15);
        chk("last_x", lx, HA - 1);
        chk("last_y", ly, VA - 1);
        chk("single_sum_prev", fd_sum[0], EXP_FULL);
        chk("single_sum", fd_sum[1], EXP_ONE);

        // Short line while locked, then relock
        clear_trk();
        gen_frame(VT, 5, 0);
        chk("short_line_fall", lock_fall, hs_err_cyc + 2);
        chk("short_line_err", err_count, 1);
        chk("short_line_no_valid", valid_after_fall, 0);
        chk("short_line_valid_before", vcnt, 3 * HA);
        clear_trk();
        for (int f = 0; f < 3; f++) gen_frame(VT, -1, 0);
        chk("relock_time", lock_rise, vs_cyc[2] + 2);
        chk("relock_err_hold", err_count, 1);

        // Async reset mid-frame while locked
        gen_frame(7, -1, 0);
        chk("locked_before_reset", locked, 1);
        nRst = 1'b0;
        #2;
        chk("async_locked", locked, 0);
        chk("async_err", err_count, 0);
        chk("async_valid", pix_valid, 0);
        chk("async_sum", frame_sum, 0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 6'h00);
        nRst = 1'b1;
        en = 1'b0;
        clear_trk();
        for (int f = 0; f < 3; f++) gen_frame(VT, -1, 0);
        chk("en_low_no_lock", lock_rise, -1);
        chk("en_low_locked", locked, 0);
        chk("en_low_no_fdone", fd_cnt, 0);
        chk("en_low_err", err_count, 0);

        // Short frame while syncing delays lock by one frame
        en = 1'b1;
        clear_trk();
        gen_frame(VT - 1, -1, 0);
        for (int f = 0; f < 4; f++) gen_frame(VT, -1, 0);
        chk("short_frame_lock", lock_rise, vs_cyc[3] + 2);
        chk("short_frame_fdone", first_fd, vs_cyc[4] + 2);
        chk("short_frame_fdone_count", fd_cnt, 1);
        chk("short_frame_sum", fd_sum[0], EXP_FULL);
        chk("short_frame_err", err_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
